// File: rtl/verificador_tabla_if.sv
// Sample stream from the stimulus source plus DUT into the checker:
// one input combination and its observed output per beat.
interface verificador_tabla_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            y_obs;

    modport master (output in_valid, in_vec, y_obs, input in_ready);
    modport slave  (input in_valid, in_vec, y_obs, output in_ready);
endinterface

// File: rtl/verificador_tabla.sv
// Truth-table response checker: compares observed samples against EXPECTED,
// tracks coverage of all 2^N_IN combinations and reports once all are seen.
module verificador_tabla #(
    parameter int                  N_IN     = 4,
    parameter logic [2**N_IN-1:0]  EXPECTED = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    verificador_tabla_if.slave   smp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic                 first_err_valid,
    output logic [N_IN-1:0]      first_err_idx,
    output logic [7:0]           dup_count,
    output logic [2**N_IN-1:0]   covered
);
    localparam int N_ENT = 2**N_IN;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             clear;
    logic             is_new;
    logic             mismatch;
    logic [N_ENT-1:0] idx_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        clear      = 1'b0;
        accept     = 1'b0;
        idx_onehot = N_ENT'(1) << smp.in_vec;
        is_new     = ~|(covered & idx_onehot);
        mismatch   = smp.y_obs != EXPECTED[smp.in_vec];
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    clear     = 1'b1;
                end
            end
            ST_RUN: begin
                accept = smp.in_valid;
                // Leave RUN on the very beat that fills the last bitmap hole.
                if (accept && is_new && (&(covered | idx_onehot)))
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign smp.in_ready = (state == ST_RUN);
    assign busy         = (state == ST_RUN);
    assign done         = (state == ST_DONE);
    assign pass         = done && (err_count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            covered         <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            dup_count       <= '0;
        end else if (clear) begin
            covered         <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            dup_count       <= '0;
        end else if (accept) begin
            if (is_new) begin
                covered <= covered | idx_onehot;
                if (mismatch) begin
                    err_count <= err_count + (N_IN+1)'(1);
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= smp.in_vec;
                    end
                end
            end else if (dup_count != 8'hFF) begin
                dup_count <= dup_count + 8'd1;
            end
        end
    end
endmodule

// File: doc/verificador_tabla.md
Name: verificador_tabla

Overview:
- Synthesizable truth-table response checker: the receiving end of the exhaustive-stimulus flow used for the lab combinational exercises.
- Accepts a stream of (input vector, observed output) samples from a stimulus source plus DUT.
- Compares each sample against a parameterised expected truth table and tracks coverage of all 2^N_IN input combinations.
- Reports pass/fail, error count, first failing index and duplicate count once every combination has been seen.

Parameters:
- N_IN, 4, number of DUT inputs (1..6); the table has 2^N_IN entries.
- EXPECTED, {2**N_IN{1'b0}}, expected truth table; bit i is the expected Y for input index i (A is the MSB of the index).

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: clear results and begin a check run
- in_valid  input  1  sample present on in_vec/y_obs
- in_vec  input  N_IN  DUT input combination (b1 is the MSB)
- y_obs  input  1  DUT output observed for in_vec
- in_ready  output  1  checker accepts samples (high only in RUN)
- busy  output  1  high in RUN
- done  output  1  high in DONE
- pass  output  1  done && err_count==0
- err_count  output  N_IN+1  count of mismatching unique indices (max 2^N_IN)
- first_err_valid  output  1  at least one mismatch recorded
- first_err_idx  output  N_IN  index of the first mismatch accepted
- dup_count  output  8  repeated-index samples ignored; saturates at 255
- covered  output  2**N_IN  bitmap of indices already checked

Behaviour:
- Reset (async, any time, including mid-run):
  - State goes to IDLE.
  - All outputs are 0: in_ready, busy, done, pass, err_count, first_err_valid, first_err_idx, dup_count, covered.
- States are IDLE, RUN and DONE. All outputs are registered or decoded directly from state.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> RUN on the next edge; counters, bitmap and first_err are cleared on that edge.
- RUN:
  - in_ready=busy=1.
  - A beat is accepted on an edge where in_valid && in_ready.
  - On accept, if covered[in_vec]==0:
    - set covered[in_vec];
    - if y_obs != EXPECTED[in_vec], err_count += 1;
    - if this is the first mismatch, latch first_err_idx=in_vec and first_err_valid=1.
  - On accept, if covered[in_vec]==1: the sample is not compared and dup_count += 1, saturating at 255.
  - Outputs update at the same edge that accepts the beat (latency 1 clock from sample to visible result).
  - If the accepted beat completes the bitmap (all ones), the state goes to DONE at that same edge.
  - start during RUN is ignored.
- DONE:
  - done=1; in_ready=0; results hold.
  - pass = (err_count==0).
  - start=1 -> RUN with a full clear, identical to starting from IDLE.
- Boundaries:
  - err_count cannot wrap: at most 2^N_IN unique indices, and the width is N_IN+1.
  - in_valid with X on in_vec while in_ready=0 has no effect.
  - A beat arriving on the same edge as start (IDLE->RUN) is not accepted, because in_ready is still 0.
  - There is no timeout: RUN persists until coverage is complete or reset.

Test Plan (N_IN=3, EXPECTED=8'b1001_0110, i.e. 3-input XOR):
1. Assert reset mid-sequence -> every output reads 0 during reset and after release; state is IDLE, in_ready=0.
2. start, then 8 correct beats for indices 0..7 back-to-back -> done=1 at the edge of the 8th beat, pass=1, err_count=0, covered=8'hFF, dup_count=0.
3. start, then 8 beats with y_obs at index 5 set to 1 (expected 0) -> done=1, pass=0, err_count=1, first_err_valid=1, first_err_idx=5.
4. start, then beats 0,1,2,2(y wrong),3..7 -> second idx 2 ignored; dup_count=1, err_count=0, pass=1, done on the beat for index 7.
5. start, then beats in order 7..0 with in_valid gaps of 0-3 cycles and wrong y at indices 6 and 1 -> err_count=2, first_err_idx=6, done only after 8 unique beats.
6. start, 4 beats accepted, then reset pulse, then start and 8 correct beats -> outputs cleared by the reset, final pass=1, covered=8'hFF; a following start from DONE clears covered to 0 and re-enters RUN.
